// File: rtl/bcd_pkg.sv
// Shared BCD widths and code helpers for the decimal scanner slice.
// Pure declarations; no latency, no flow control.
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int DEC_W = 10;

  function automatic logic bcd_is_valid(input logic [BCD_W-1:0] code);
    return code <= 4'd9;
  endfunction

  // Codes 10..15 have no decimal line and decode to all-zero.
  function automatic logic [DEC_W-1:0] bcd_to_onehot(input logic [BCD_W-1:0] code);
    logic [DEC_W-1:0] res;
    res = '0;
    if (bcd_is_valid(code)) res = {{(DEC_W-1){1'b0}}, 1'b1} << code;
    return res;
  endfunction
endpackage

// File: rtl/bcd_onehot_dec.sv
// Combinational 4->10 one-hot BCD decoder with code-valid flag.
// Zero latency; no flow control.
module bcd_onehot_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [DEC_W-1:0] onehot,
  output logic             valid
);
  assign onehot = bcd_to_onehot(code);
  assign valid  = bcd_is_valid(code);
endmodule

// File: rtl/bcd_decimal_scanner.sv
// Latches NUM_DIGITS BCD digits and scans them one per SCAN_DIV-cycle slot with registered outputs.
// One-cycle output latency; no backpressure, the scan free-runs.
module bcd_decimal_scanner
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        blank_lz,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic [DEC_W-1:0]            dec_out,
  output logic                        invalid,
  output logic                        err_any,
  output logic                        frame_done
);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [BCD_W*NUM_DIGITS-1:0] digits;
  logic [PRE_W-1:0]            pre;
  logic [IDX_W-1:0]            idx;

  logic [BCD_W-1:0]      cur_code;
  logic [DEC_W-1:0]      cur_onehot;
  logic                  cur_valid;
  logic [NUM_DIGITS-1:0] zero_from;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic                  run_zero;
  logic                  any_bad;
  logic                  blank_cur;
  logic                  slot_end;
  logic                  scan_wrap;

  assign cur_code = digits[BCD_W*idx +: BCD_W];

  bcd_onehot_dec u_dec (
    .code   (cur_code),
    .onehot (cur_onehot),
    .valid  (cur_valid)
  );

  // zero_from[i]: digits i..MSD are all 0000; an invalid code is non-zero here.
  always_comb begin
    zero_from = '0;
    sel_nxt   = '0;
    any_bad   = 1'b0;
    run_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (digits[BCD_W*i +: BCD_W] == '0);
      zero_from[i] = run_zero;
      any_bad      = any_bad || !bcd_is_valid(digits[BCD_W*i +: BCD_W]);
      sel_nxt[i]   = (idx == IDX_W'(i));
    end
  end

  assign blank_cur = blank_lz && (idx != '0) && zero_from[idx];
  assign slot_end  = (pre == PRE_LAST);
  assign scan_wrap = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      digits     <= '0;
      pre        <= '0;
      idx        <= '0;
      dig_sel    <= '0;
      dec_out    <= '0;
      invalid    <= 1'b0;
      err_any    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Outputs reflect the pre-edge digits and index; a load this edge shows next edge.
      dig_sel    <= sel_nxt;
      dec_out    <= blank_cur ? '0 : cur_onehot;
      invalid    <= !cur_valid;
      err_any    <= any_bad;
      frame_done <= scan_wrap;
      if (load) digits <= bcd_in;
      if (slot_end) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_decimal_scanner.sv
// Checks a 4-digit/2-cycle scanner and a 1-digit/1-cycle scanner against a slot-arithmetic model.
// Directed steps followed by a randomized load/blank/reset phase.
module tb_bcd_decimal_scanner;
  logic        clk = 1'b0;
  logic        reset, load, blank_lz;
  logic [15:0] bcd_in;

  logic [3:0] a_dig_sel;
  logic [9:0] a_dec_out;
  logic       a_invalid, a_err_any, a_frame_done;
  logic [0:0] b_dig_sel;
  logic [9:0] b_dec_out;
  logic       b_invalid, b_err_any, b_frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: latched digits and edges since reset release
  logic [15:0] m_lat = '0;
  int          m_t   = 0;

  always #5 clk = ~clk;

  bcd_decimal_scanner #(.NUM_DIGITS(4), .SCAN_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in), .blank_lz(blank_lz),
    .dig_sel(a_dig_sel), .dec_out(a_dec_out), .invalid(a_invalid),
    .err_any(a_err_any), .frame_done(a_frame_done)
  );

  bcd_decimal_scanner #(.NUM_DIGITS(1), .SCAN_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .bcd_in(bcd_in[3:0]), .blank_lz(blank_lz),
    .dig_sel(b_dig_sel), .dec_out(b_dec_out), .invalid(b_invalid),
    .err_any(b_err_any), .frame_done(b_frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic [15:0] lat, input int i);
    return int'((lat >> (4 * i)) & 16'hF);
  endfunction

  function automatic void model(input int n, input int s, input logic [15:0] lat, input int t,
                                input bit blz, output logic [3:0] sel, output logic [9:0] dec,
                                output logic inv, output logic err, output logic fd);
    int  slot, code;
    bit  upper_zero;
    slot = (t / s) % n;
    code = digit_of(lat, slot);
    upper_zero = 1'b1;
    for (int j = slot; j < n; j++) if (digit_of(lat, j) != 0) upper_zero = 1'b0;
    sel = 4'(1 << slot);
    inv = (code > 9);
    dec = (code <= 9 && !(blz && slot > 0 && upper_zero)) ? 10'(1 << code) : 10'h000;
    err = 1'b0;
    for (int j = 0; j < n; j++) if (digit_of(lat, j) > 9) err = 1'b1;
    fd  = ((t % (n * s)) == n * s - 1);
  endfunction

  task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit blz);
    logic [3:0] ea_sel, eb_sel;
    logic [9:0] ea_dec, eb_dec;
    logic       ea_inv, ea_err, ea_fd, eb_inv, eb_err, eb_fd;
    reset = r; load = ld; bcd_in = v; blank_lz = blz;
    @(posedge clk);
    if (r) begin
      {ea_sel, ea_dec, ea_inv, ea_err, ea_fd} = '0;
      {eb_sel, eb_dec, eb_inv, eb_err, eb_fd} = '0;
      m_lat = '0;
      m_t   = 0;
    end else begin
      model(4, 2, m_lat, m_t, blz, ea_sel, ea_dec, ea_inv, ea_err, ea_fd);
      model(1, 1, m_lat, m_t, blz, eb_sel, eb_dec, eb_inv, eb_err, eb_fd);
      m_t++;
      if (ld) m_lat = v;
    end
    #1;
    chk("a_dig_sel", a_dig_sel, ea_sel);
    chk("a_dec_out", a_dec_out, ea_dec);
    chk("a_invalid", a_invalid, ea_inv);
    chk("a_err_any", a_err_any, ea_err);
    chk("a_frame_done", a_frame_done, ea_fd);
    chk("b_dig_sel", b_dig_sel, eb_sel);
    chk("b_dec_out", b_dec_out, eb_dec);
    chk("b_invalid", b_invalid, eb_inv);
    chk("b_err_any", b_err_any, eb_err);
    chk("b_frame_done", b_frame_done, eb_fd);
  endtask

  task automatic idle(input int n, input bit blz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, blz);
  endtask

  logic [9:0]  basic_dec [4];
  logic [15:0] rv;
  bit          rblz;

  initial begin
    basic_dec[0] = 10'h080; basic_dec[1] = 10'h008; basic_dec[2] = 10'h200; basic_dec[3] = 10'h002;
    reset = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;

    // reset state
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 1'b0);

    // basic scan of 1937, then one full frame checked against literal values
    step(1'b0, 1'b1, 16'h1937, 1'b0);
    idle(7, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("basic_sel", a_dig_sel, 32'(1 << (c / 2)));
      chk("basic_dec", a_dec_out, basic_dec[c / 2]);
      chk("basic_frame_done", a_frame_done, (c == 7) ? 32'd1 : 32'd0);
    end

    // leading-zero blanking
    step(1'b0, 1'b1, 16'h0040, 1'b1);
    idle(9, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(9, 1'b1);
    idle(8, 1'b0);

    // invalid digit, then recovery
    step(1'b0, 1'b1, 16'h12A4, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("err_any_after_load", a_err_any, 32'd1);
    idle(8, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(9, 1'b0);

    // load during digit 2's first slot cycle
    while (m_t % 8 != 4) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("midload_dec", a_dec_out, 32'h020);
    idle(10, 1'b0);

    // reset during digit 2, then a full frame after release
    while (m_t % 8 != 4) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("post_reset_dec", a_dec_out, 32'h001);
    idle(9, 1'b0);

    // degenerate instance with a 7 latched
    step(1'b0, 1'b1, 16'h0007, 1'b1);
    idle(3, 1'b1);
    chk("degen_dec", b_dec_out, 32'h080);

    // randomized loads, blank mode changes and occasional resets
    rblz = 1'b0;
    for (int k = 0; k < 600; k++) begin
      rv = '0;
      for (int d = 0; d < 4; d++) begin
        int pick;
        pick = $urandom_range(0, 9);
        if (pick < 4)       rv[4*d +: 4] = 4'd0;
        else if (pick == 9) rv[4*d +: 4] = 4'($urandom_range(10, 15));
        else                rv[4*d +: 4] = 4'($urandom_range(1, 9));
      end
      if ($urandom_range(0, 15) == 0) rblz = ~rblz;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, rv, rblz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_decimal_scanner.md
Name: bcd_decimal_scanner

Overview:
Parametrised multi-digit successor to the single-digit BCD-to-decimal decoder. It latches NUM_DIGITS packed BCD digits on a load strobe and time-multiplexes them, one digit per scan slot. For the active slot it drives a one-hot digit select and a 10-line one-hot decimal output. It adds what the single-digit decoder lacks: registered outputs, a prescaled scan, leading-zero blanking, invalid-code flags and a frame-done pulse. It sits between the BCD counter/arithmetic logic and a multiplexed decimal display driver.

Parameters:
NUM_DIGITS, 4, number of BCD digits scanned (>=1); digit 0 is least significant.
SCAN_DIV, 2, clock cycles each digit stays displayed (>=1).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  latch bcd_in at this edge
bcd_in  input  4*NUM_DIGITS  packed digits; digit i = bcd_in[4i+3:4i]
blank_lz  input  1  1 = blank leading zeros (runtime mode)
dig_sel  output  NUM_DIGITS  one-hot active digit
dec_out  output  10  one-hot decimal; bit k = value k; all-zero = blank
invalid  output  1  active digit code is 10..15
err_any  output  1  any latched digit code is 10..15
frame_done  output  1  one-cycle pulse in the last cycle of a frame

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset contents: reset=1 at an edge clears the latched digits, prescaler pre and index idx to 0. It also drives every output to 0: dig_sel, dec_out, invalid, err_any and frame_done. load is ignored while reset=1.
- Output timing: all outputs are registered. At each non-reset edge the outputs are computed from the pre-edge idx and latched digits. pre and idx then update.
- Scan counter: pre counts 0..SCAN_DIV-1. When pre==SCAN_DIV-1, pre returns to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
- Scan result: after reset release, digit 0 appears at the first edge. Each digit shows for exactly SCAN_DIV cycles. A frame is NUM_DIGITS*SCAN_DIV cycles.
- Degenerate case: with SCAN_DIV=1 and NUM_DIGITS=1, idx stays 0, dig_sel stays 1 and frame_done is high every cycle.
- dig_sel: one-hot of idx.
- dec_out: one-hot of the active code when the code is 0..9 and not blanked; otherwise 0.
- invalid: 1 when the active code is 10..15. Its dec_out is then 0.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and digits i..NUM_DIGITS-1 are all 0000.
  - Digit 0 is never blanked.
  - An invalid code counts as non-zero, so it stops blanking of lower digits.
  - dig_sel is still asserted for a blanked digit.
- frame_done: registered with (idx==NUM_DIGITS-1 && pre==SCAN_DIV-1). It is high during the final display cycle of the most significant digit.
- Load: at edge k, load=1 latches bcd_in. The outputs at edge k still use the old digits; the new digits are used from edge k+1.
  - Load does not restart the scan.
  - err_any updates at edge k+1 from the newly latched digits.
  - Back-to-back loads: the last one wins.
- blank_lz: sampled combinationally at each edge, so a change takes effect at the next edge.
- Reset mid-frame: all state clears at that edge. After release, the scan restarts at digit 0 showing 0 (dec_out=10'h001), and no partial frame_done pulse is emitted.

Decomposition:
- Shared package/include bcd_pkg:
  - BCD_W=4, DEC_W=10.
  - Function bcd_is_valid(code).
  - Function bcd_to_onehot(code), returning 0 for 10..15.
- One sub-module, bcd_onehot_dec: a combinational 4->10 one-hot decoder with valid output. It is instantiated once, on the digit muxed by idx.
- Counters, latch, blanking logic and output registers stay in the top module.

Test Plan (NUM_DIGITS=4, SCAN_DIV=2 unless noted):
1. Basic scan: reset, then load bcd_in=16'h1937 with blank_lz=0. Required sequence, 2 cycles each:
   - dig_sel=0001, dec_out=10'h080
   - dig_sel=0010, dec_out=10'h008
   - dig_sel=0100, dec_out=10'h200
   - dig_sel=1000, dec_out=10'h002
   frame_done is high only in the 8th cycle of the frame.
2. Blanking: load 16'h0040 with blank_lz=1 -> digit3 and digit2 dec_out=0, digit1 10'h010, digit0 10'h001. Load 16'h0000 -> only digit0 non-blank (10'h001). Set blank_lz=0 -> digit3 and digit2 show 10'h001.
3. Invalid code: load 16'h12A4 -> err_any=1 one cycle after load; in digit1's slot dec_out=0 and invalid=1, with digit2 10'h004 and digit3 10'h002. Reload 16'h1234 -> err_any returns to 0.
4. Load mid-frame: load 16'h5555 during digit2's first slot cycle -> digit2's second cycle shows 10'h020, idx continues to digit3 with no restart, and the frame_done cadence is unchanged.
5. Reset mid-frame: assert reset for 1 cycle during digit2 -> next edge all outputs 0. After release, dig_sel=0001 and dec_out=10'h001, and the next frame_done arrives 8 cycles after release.
6. Degenerate parameters NUM_DIGITS=1, SCAN_DIV=1: load 4'h7 -> dig_sel=1 constantly, dec_out=10'h080, frame_done high every cycle after reset release.
